// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller sharing one external BCD decoder across NUM_DIGITS.
// Optional leading-zero blanking is compiled in when SEG_LZ_BLANK_EN is defined.
module seven_seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 50000,
  parameter int unsigned GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  output logic                    update_pending,
  output logic [4:0]              dec_bcd,
  input  logic [6:0]              dec_seven,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned SlotW = $clog2(NUM_DIGITS);
  localparam int unsigned CntW  = $clog2(PRESCALE);
  localparam logic [CntW-1:0]  CntMax   = CntW'(PRESCALE - 1);
  localparam logic [CntW-1:0]  GuardEnd = CntW'(GUARD - 1);
  localparam logic [SlotW-1:0] LastSlot = SlotW'(NUM_DIGITS - 1);
  localparam logic [6:0]       SegOff   = 7'h7F;
  localparam logic [6:0]       SegDash  = 7'b0111111;

  typedef enum logic [1:0] {StIdle, StGuard, StDrive} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         count_q, count_d;
  logic [SlotW-1:0]        slot_q, slot_d;
  logic [4*NUM_DIGITS-1:0] disp_q, stage_q;
  logic                    pend_q;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_q;
  logic                    tick, boundary;
  logic [3:0]              cur_digit;
  logic                    cur_blank;

  always_comb begin
    cur_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SlotW'(i)) cur_digit = disp_q[4*i +: 4];
    end
  end

`ifdef SEG_LZ_BLANK_EN
  // Blank zeros from the top digit down until the first nonzero; digit 0 always shows.
  logic [NUM_DIGITS-1:0] lz_mask;
  always_comb begin
    logic seen;
    seen       = 1'b0;
    lz_mask    = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if (disp_q[4*i +: 4] != 4'd0) seen = 1'b1;
      lz_mask[i] = ~seen;
    end
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SlotW'(i)) cur_blank = lz_mask[i];
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  assign dec_bcd = {1'b0, cur_digit};

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    slot_d  = slot_q;
    tick    = enable && (state_q == StDrive) && (count_q == CntMax);
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StGuard;
          count_d = '0;
        end
        StGuard: begin
          count_d = count_q + CntW'(1);
          if (count_q == GuardEnd) state_d = StDrive;
        end
        StDrive: begin
          if (tick) begin
            count_d = '0;
            slot_d  = (slot_q == LastSlot) ? '0 : slot_q + SlotW'(1);
            state_d = StGuard;
          end else begin
            count_d = count_q + CntW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  assign boundary = tick && (slot_q == LastSlot);

  // Outputs are registered from the next state so an/seg line up with the slot they belong to.
  always_comb begin
    an_d = '1;
    if (state_d == StDrive) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (slot_d == SlotW'(i)) an_d[i] = 1'b0;
      end
    end
    if (state_d == StIdle)   seg_d = SegOff;
    else if (cur_digit > 9)  seg_d = SegDash;
    else if (cur_blank)      seg_d = SegOff;
    else                     seg_d = dec_seven;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      slot_q  <= '0;
      disp_q  <= '0;
      stage_q <= '0;
      pend_q  <= 1'b0;
      seg_q   <= SegOff;
      an_q    <= '1;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      frame_q <= boundary;
      if (load && boundary) begin
        disp_q  <= digits_in;
        stage_q <= digits_in;
        pend_q  <= 1'b0;
      end else if (load) begin
        stage_q <= digits_in;
        pend_q  <= 1'b1;
      end else if (boundary && pend_q) begin
        disp_q <= stage_q;
        pend_q <= 1'b0;
      end
    end
  end

  assign update_pending = pend_q;
  assign seg            = seg_q;
  assign an             = an_q;
  assign frame_done     = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl against a slot/phase reference model.
// Honors SEG_LZ_BLANK_EN in its model when that macro is defined for the build.
module tb_seven_seg_scan_ctrl;

  localparam int N  = 4;
  localparam int PS = 4;
  localparam int GD = 1;

  logic        clk = 1'b0;
  logic        reset_n, enable, load;
  logic [15:0] digits_in;
  logic        update_pending, frame_done;
  logic [4:0]  dec_bcd;
  logic [6:0]  dec_seven, seg;
  logic [3:0]  an;
  logic [6:0]  dec_tab [16];

  always #5 clk = ~clk;

  assign dec_seven = dec_tab[dec_bcd[3:0]];

  seven_seg_scan_ctrl #(.NUM_DIGITS(N), .PRESCALE(PS), .GUARD(GD)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .digits_in(digits_in), .load(load),
    .update_pending(update_pending), .dec_bcd(dec_bcd), .dec_seven(dec_seven), .seg(seg),
    .an(an), .frame_done(frame_done)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: phase within slot, current slot, images and pending flag.
  int          p, s;
  bit          running, mpend, mfd;
  logic [15:0] mdisp, mstage;
  logic [6:0]  mseg;
  logic [3:0]  man;

  function automatic logic [3:0] digit_of(logic [15:0] img, int idx);
    logic [15:0] t;
    t = img >> (4 * idx);
    return t[3:0];
  endfunction

  function automatic bit lz_blank(logic [15:0] img, int idx);
`ifdef SEG_LZ_BLANK_EN
    return (idx > 0) && ((img >> (4 * idx)) == 16'd0);
`else
    return (idx < 0) && (img != img);
`endif
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit en, input bit ld, input logic [15:0] din);
    logic [3:0] nd;
    bit         bnd;
    reset_n = ~rst; enable = en; load = ld; digits_in = din;
    @(posedge clk);
    cyc++;
    if (rst) begin
      p = 0; s = 0; running = 0; mdisp = 0; mstage = 0; mpend = 0; mfd = 0;
      mseg = 7'h7F; man = 4'hF;
    end else begin
      nd = digit_of(mdisp, s);
      if (!en)                    mseg = 7'h7F;
      else if (nd > 9)            mseg = 7'b0111111;
      else if (lz_blank(mdisp, s)) mseg = 7'h7F;
      else                        mseg = dec_tab[nd];
      bnd = running && en && (p == PS - 1) && (s == N - 1);
      if (ld && bnd) begin
        mdisp = din; mstage = din; mpend = 0;
      end else if (ld) begin
        mstage = din; mpend = 1;
      end else if (bnd && mpend) begin
        mdisp = mstage; mpend = 0;
      end
      mfd = bnd;
      if (!en) running = 0;
      else if (!running) begin
        running = 1; p = 0;
      end else if (p == PS - 1) begin
        p = 0; s = (s + 1) % N;
      end else p++;
      man = (running && p >= GD) ? ~(4'(1) << s) : 4'hF;
    end
    #1;
    chk("seg", 16'(seg), 16'(mseg));
    chk("an", 16'(an), 16'(man));
    chk("frame_done", 16'(frame_done), 16'(mfd));
    chk("update_pending", 16'(update_pending), 16'(mpend));
    chk("dec_bcd", 16'(dec_bcd), {12'd0, digit_of(mdisp, s)});
  endtask

  initial begin
    bit found;
    logic [15:0] d;
    dec_tab[0] = 7'h40; dec_tab[1] = 7'h79; dec_tab[2] = 7'h24; dec_tab[3] = 7'h30;
    dec_tab[4] = 7'h19; dec_tab[5] = 7'h12; dec_tab[6] = 7'h02; dec_tab[7] = 7'h78;
    dec_tab[8] = 7'h00; dec_tab[9] = 7'h10;
    // Codes above 9 return junk the controller must ignore.
    for (int i = 10; i < 16; i++) dec_tab[i] = {1'b1, 6'($urandom)};
    reset_n = 0; enable = 0; load = 0; digits_in = 0;

    // Reset, including with enable and load active.
    step(1, 0, 0, 16'h0);
    step(1, 1, 1, 16'h5555);
    step(1, 1, 0, 16'h0);
    chk("reset_seg", 16'(seg), 16'h007F);
    chk("reset_an", 16'(an), 16'h000F);

    // Start scanning, then load 1234.
    step(0, 1, 0, 16'h0);
    step(0, 1, 0, 16'h0);
    chk("first_drive_an", 16'(an), 16'h000E);
    step(0, 1, 1, 16'h1234);
    for (int i = 0; i < 40; i++) step(0, 1, 0, 16'h0);

    // Load exactly on the frame boundary.
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      if (running && p == PS - 1 && s == N - 1) found = 1;
      else step(0, 1, 0, 16'h0);
    end
    chk("boundary_found", 16'(found), 16'd1);
    step(0, 1, 1, 16'h0009);
    chk("boundary_load_pend", 16'(update_pending), 16'd0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h1111);
    step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h2222);
    for (int i = 0; i < 36; i++) step(0, 1, 0, 16'h0);

    // Out-of-range digit in slot 2, then leading-zero images.
    step(0, 1, 1, 16'h0B00);
    for (int i = 0; i < 36; i++) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h0050);
    for (int i = 0; i < 36; i++) step(0, 1, 0, 16'h0);
    step(0, 1, 1, 16'h0000);
    for (int i = 0; i < 36; i++) step(0, 1, 0, 16'h0);

    // Drop enable mid-DRIVE, then resume.
    found = 0;
    for (int k = 0; k < 64 && !found; k++) begin
      if (running && p >= GD && p < PS - 1 && s == 2) found = 1;
      else step(0, 1, 0, 16'h0);
    end
    chk("drive_found", 16'(found), 16'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 16'h0);
    chk("idle_an", 16'(an), 16'h000F);
    chk("idle_dec_bcd", 16'(dec_bcd), 16'h0000);
    for (int i = 0; i < 24; i++) step(0, 1, 0, 16'h0);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      d = 16'h0;
      for (int j = 0; j < N; j++)
        d = d | (16'(($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, 15)) << (4 * j));
      step(($urandom_range(0, 249) == 0), ($urandom_range(0, 15) != 0),
           ($urandom_range(0, 9) == 0), d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
